// File: rtl/pipelined_ram.sv
// Parametrised single-port synchronous RAM with byte-lane writes, a 1- or 2-cycle read
// pipeline, selectable read-during-write behaviour and a reset-time clear sweep.
module pipelined_ram #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 9,
    parameter int READ_LATENCY   = 1,
    parameter bit WRITE_FIRST    = 1'b0,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    Read,
    input  logic                    Write,
    input  logic [DATA_WIDTH/8-1:0] ByteEn,
    input  logic [ADDR_WIDTH-1:0]   address,
    input  logic [DATA_WIDTH-1:0]   DataIn,
    output logic [DATA_WIDTH-1:0]   DataOut,
    output logic                    DataValid,
    output logic                    Ready
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic {CLEAR, RUN} state_t;

    state_t                  state;
    state_t                  next_state;
    logic [ADDR_WIDTH-1:0]   sweep_cnt;
    logic                    sweep_last;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [DATA_WIDTH-1:0]   old_word;
    logic [DATA_WIDTH-1:0]   merged_word;
    logic [DATA_WIDTH-1:0]   read_word;
    logic                    wr_en;
    logic                    rd_en;
    logic                    pipe_valid;
    logic [DATA_WIDTH-1:0]   pipe_data;

    assign sweep_last = (sweep_cnt == {ADDR_WIDTH{1'b1}});
    assign wr_en      = Ready && Write;
    assign rd_en      = Ready && Read;
    assign old_word   = mem[address];

    always_comb begin
        merged_word = old_word;
        for (int i = 0; i < BYTES; i++) begin
            if (ByteEn[i]) begin
                merged_word[8*i +: 8] = DataIn[8*i +: 8];
            end
        end
    end

    // Write-first builds forward the merged word so partial byte enables are visible.
    assign read_word = (WRITE_FIRST && wr_en) ? merged_word : old_word;

    always_comb begin
        next_state = state;
        if (state == CLEAR && sweep_last) begin
            next_state = RUN;
        end
    end

    // Ready is registered so it stays low through reset even when no sweep is run.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= CLEAR_ON_RESET ? CLEAR : RUN;
            sweep_cnt <= '0;
            Ready     <= 1'b0;
        end else begin
            state <= next_state;
            Ready <= (next_state == RUN);
            if (state == CLEAR && !sweep_last) begin
                sweep_cnt <= sweep_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (state == CLEAR) begin
            mem[sweep_cnt] <= '0;
        end else if (wr_en) begin
            mem[address] <= merged_word;
        end
    end

    // DataOut only moves when a read completes; it holds between reads.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pipe_valid <= 1'b0;
            pipe_data  <= '0;
            DataValid  <= 1'b0;
            DataOut    <= '0;
        end else begin
            pipe_valid <= rd_en;
            if (rd_en) begin
                pipe_data <= read_word;
            end
            if (READ_LATENCY == 2) begin
                DataValid <= pipe_valid;
                if (pipe_valid) begin
                    DataOut <= pipe_data;
                end
            end else begin
                DataValid <= rd_en;
                if (rd_en) begin
                    DataOut <= read_word;
                end
            end
        end
    end

endmodule
